// File: rtl/input_conditioner.sv
// Synchronizes and glitch-filters the four raw scenario inputs, makes rising-edge strobes,
// and measures/locks onto the phase period. Define GLITCH_CNT_EN to build the phase glitch counter.
module input_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int PERIOD_W    = 16,
    parameter int LOCK_TOL    = 4,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                clock,
    input  logic                reset_signal,
    input  logic                start_raw,
    input  logic                fg_opto_raw,
    input  logic                phase_raw,
    input  logic                detector_ready_raw,
    output logic                start_f,
    output logic                start_rise,
    output logic                fg_opto_f,
    output logic                fg_opto_rise,
    output logic                phase_f,
    output logic                phase_rise,
    output logic                detector_ready_f,
    output logic [PERIOD_W-1:0] phase_period,
    output logic                period_valid,
    output logic                phase_locked,
    output logic [15:0]         glitch_count
);

    localparam int RUN_W  = $clog2(FILTER_LEN + 1);
    localparam int MCNT_W = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} lock_state_e;

    // Channel order: 0 start, 1 fg_opto, 2 phase, 3 detector_ready
    logic [3:0]                  raw;
    logic [3:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [3:0]                  synced;
    logic [3:0]                  prev_q, prev_d;
    logic [3:0]                  filt_q, filt_d;
    logic [3:0]                  rise_q, rise_d;
    logic [3:0][RUN_W-1:0]       run_q, run_d;

    assign raw = {detector_ready_raw, phase_raw, fg_opto_raw, start_raw};

    // run counts cycles (including the current one) the synced level has held, saturating
    always_comb begin
        for (int unsigned c = 0; c < 4; c++) begin
            sync_d[c] = {sync_q[c][SYNC_STAGES-2:0], raw[c]};
            synced[c] = sync_q[c][SYNC_STAGES-1];
            prev_d[c] = synced[c];
            if (synced[c] != prev_q[c]) begin
                run_d[c] = RUN_W'(1);
            end else if (run_q[c] == RUN_W'(FILTER_LEN)) begin
                run_d[c] = run_q[c];
            end else begin
                run_d[c] = run_q[c] + RUN_W'(1);
            end
            filt_d[c] = filt_q[c];
            if (run_d[c] == RUN_W'(FILTER_LEN) && synced[c] != filt_q[c]) begin
                filt_d[c] = synced[c];
            end
            rise_d[c] = filt_d[c] & ~filt_q[c];
        end
    end

    always_ff @(posedge clock or negedge reset_signal) begin
        if (!reset_signal) begin
            sync_q <= '0;
            prev_q <= '0;
            filt_q <= '0;
            rise_q <= '0;
            run_q  <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            filt_q <= filt_d;
            rise_q <= rise_d;
            run_q  <= run_d;
        end
    end

    assign start_f          = filt_q[0];
    assign start_rise       = rise_q[0];
    assign fg_opto_f        = filt_q[1];
    assign fg_opto_rise     = rise_q[1];
    assign phase_f          = filt_q[2];
    assign phase_rise       = rise_q[2];
    assign detector_ready_f = filt_q[3];

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] new_period;
    logic [PERIOD_W:0]   diff;
    logic                valid_q, valid_d;
    logic                sat, match;
    logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
    lock_state_e         state_q, state_d;

    // A rise in IDLE always re-arms, even with the counter pinned at saturation
    always_comb begin
        sat        = (cnt_q == '1);
        new_period = cnt_q + PERIOD_W'(1);
        diff       = (new_period >= period_q) ? ({1'b0, new_period} - {1'b0, period_q})
                                              : ({1'b0, period_q} - {1'b0, new_period});
        match      = valid_q && (diff <= (PERIOD_W + 1)'(LOCK_TOL));

        cnt_d = sat ? cnt_q : cnt_q + PERIOD_W'(1);
        if (rise_q[2]) cnt_d = '0;

        state_d  = state_q;
        period_d = period_q;
        valid_d  = valid_q;
        mcnt_d   = mcnt_q;
        case (state_q)
            IDLE: begin
                if (rise_q[2]) begin
                    state_d = MEASURE;
                    mcnt_d  = '0;
                end
            end
            MEASURE, LOCKED: begin
                if (sat) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    mcnt_d  = '0;
                end else if (rise_q[2]) begin
                    period_d = new_period;
                    valid_d  = 1'b1;
                    if (match) begin
                        if (mcnt_q != MCNT_W'(LOCK_COUNT)) mcnt_d = mcnt_q + MCNT_W'(1);
                        if (mcnt_d == MCNT_W'(LOCK_COUNT)) state_d = LOCKED;
                    end else begin
                        mcnt_d  = '0;
                        state_d = MEASURE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_signal) begin
        if (!reset_signal) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset_signal) begin
        if (!reset_signal) begin
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            mcnt_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            mcnt_q   <= mcnt_d;
        end
    end

    assign phase_period = period_q;
    assign period_valid = valid_q;
    assign phase_locked = (state_q == LOCKED);

`ifdef GLITCH_CNT_EN
    logic [15:0] glitch_q, glitch_d;
    logic        glitch_ev;

    // An aborted run toward a new phase level counts as one rejected glitch
    always_comb begin
        glitch_ev = (synced[2] != prev_q[2]) && (prev_q[2] != filt_q[2])
                    && (run_q[2] < RUN_W'(FILTER_LEN));
        glitch_d  = (glitch_ev && glitch_q != '1) ? glitch_q + 16'd1 : glitch_q;
    end

    always_ff @(posedge clock or negedge reset_signal) begin
        if (!reset_signal) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_count = glitch_q;
`else
    assign glitch_count = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: a default instance and a PERIOD_W=8 instance share stimulus and
// are checked every cycle against a sample-history/timestamp model, plus literal spot checks.
module tb_input_conditioner;

    localparam int FL   = 4;
    localparam int TOL  = 4;
    localparam int LCNT = 4;
`ifdef GLITCH_CNT_EN
    localparam bit GL_ON = 1'b1;
`else
    localparam bit GL_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic st_raw, fg_raw, ph_raw, dr_raw;

    logic a_st_f, a_st_r, a_fg_f, a_fg_r, a_ph_f, a_ph_r, a_dr_f, a_valid, a_lock;
    logic [15:0] a_per, a_gl;
    logic b_st_f, b_st_r, b_fg_f, b_fg_r, b_ph_f, b_ph_r, b_dr_f, b_valid, b_lock;
    logic [7:0]  b_per;
    logic [15:0] b_gl;

    always #5 clk = ~clk;

    input_conditioner dut16 (
        .clock(clk), .reset_signal(rst_n),
        .start_raw(st_raw), .fg_opto_raw(fg_raw), .phase_raw(ph_raw), .detector_ready_raw(dr_raw),
        .start_f(a_st_f), .start_rise(a_st_r), .fg_opto_f(a_fg_f), .fg_opto_rise(a_fg_r),
        .phase_f(a_ph_f), .phase_rise(a_ph_r), .detector_ready_f(a_dr_f),
        .phase_period(a_per), .period_valid(a_valid), .phase_locked(a_lock), .glitch_count(a_gl)
    );

    input_conditioner #(.PERIOD_W(8)) dut8 (
        .clock(clk), .reset_signal(rst_n),
        .start_raw(st_raw), .fg_opto_raw(fg_raw), .phase_raw(ph_raw), .detector_ready_raw(dr_raw),
        .start_f(b_st_f), .start_rise(b_st_r), .fg_opto_f(b_fg_f), .fg_opto_rise(b_fg_r),
        .phase_f(b_ph_f), .phase_rise(b_ph_r), .detector_ready_f(b_dr_f),
        .phase_period(b_per), .period_valid(b_valid), .phase_locked(b_lock), .glitch_count(b_gl)
    );

    logic [8:0]  flags_a, flags_b;
    logic [40:0] all_a;
    logic [32:0] all_b;
    logic [3:0]  raw_vec;
    assign flags_a = {a_st_f, a_st_r, a_fg_f, a_fg_r, a_ph_f, a_ph_r, a_dr_f, a_valid, a_lock};
    assign flags_b = {b_st_f, b_st_r, b_fg_f, b_fg_r, b_ph_f, b_ph_r, b_dr_f, b_valid, b_lock};
    assign all_a   = {flags_a, a_per, a_gl};
    assign all_b   = {flags_b, b_per, b_gl};
    assign raw_vec = {dr_raw, ph_raw, fg_raw, st_raw};

    // Model: smp[c][j] is the raw level sampled j edges ago; periods come from rise timestamps
    logic [15:0] smp [4];
    logic [3:0]  mf, mr;
    int          mg;
    int          edge_n;
    int          lr [2];
    int          mper [2];
    int          mmatch [2];
    bit          mvalid [2];
    bit          mlock [2];
    bit          mact [2];
    int          maxp [2] = '{65535, 255};
    int          el;
    bit          st, hit, old;

    function automatic bit steady(input logic [15:0] h, input int from);
        steady = 1'b1;
        for (int j = from + 1; j < from + FL; j++) begin
            if (h[j] != h[from]) steady = 1'b0;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 4; c++) smp[c] = '0;
            mf = '0; mr = '0; mg = 0; edge_n = 0;
            for (int k = 0; k < 2; k++) begin
                lr[k] = -1; mper[k] = 0; mmatch[k] = 0;
                mvalid[k] = 1'b0; mlock[k] = 1'b0; mact[k] = 1'b0;
            end
        end else begin
            edge_n = edge_n + 1;
            for (int k = 0; k < 2; k++) begin
                el = edge_n - 1 - lr[k];
                st = ((el - 1) >= maxp[k]);
                if (mr[2]) lr[k] = edge_n - 1;
                if (mact[k] && st) begin
                    mact[k] = 1'b0; mvalid[k] = 1'b0; mlock[k] = 1'b0; mmatch[k] = 0;
                end else if (mr[2]) begin
                    if (!mact[k]) begin
                        mact[k] = 1'b1; mmatch[k] = 0;
                    end else begin
                        hit = mvalid[k] && (((el > mper[k]) ? el - mper[k] : mper[k] - el) <= TOL);
                        mper[k] = el; mvalid[k] = 1'b1;
                        if (hit) begin
                            mmatch[k] = mmatch[k] + 1;
                            if (mmatch[k] >= LCNT) mlock[k] = 1'b1;
                        end else begin
                            mmatch[k] = 0; mlock[k] = 1'b0;
                        end
                    end
                end
            end
            for (int c = 0; c < 4; c++) smp[c] = {smp[c][14:0], raw_vec[c]};
            if (smp[2][2] != smp[2][3] && smp[2][3] != mf[2] && !steady(smp[2], 3) && mg != 65535)
                mg = mg + 1;
            for (int c = 0; c < 4; c++) begin
                old = mf[c];
                if (steady(smp[c], 2) && smp[c][2] != mf[c]) mf[c] = smp[c][2];
                mr[c] = mf[c] & ~old;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int fg_rise_seen = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic cycle_check();
        logic [6:0] ef;
        ef = {mf[0], mr[0], mf[1], mr[1], mf[2], mr[2], mf[3]};
        if (a_fg_r) fg_rise_seen++;
        chk("a_flags",  64'(flags_a), 64'({ef, mvalid[0], mlock[0]}));
        chk("a_period", 64'(a_per),   64'(mper[0]));
        chk("a_glitch", 64'(a_gl),    GL_ON ? 64'(mg) : 64'd0);
        chk("b_flags",  64'(flags_b), 64'({ef, mvalid[1], mlock[1]}));
        chk("b_period", 64'(b_per),   64'(mper[1]));
        chk("b_glitch", 64'(b_gl),    GL_ON ? 64'(mg) : 64'd0);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            cycle_check();
        end
    endtask

    task automatic wave(input int h, input int l);
        ph_raw = 1'b1; tick(h);
        ph_raw = 1'b0; tick(l);
    endtask

    initial begin
        st_raw = 1'b1; fg_raw = 1'b1; ph_raw = 1'b1; dr_raw = 1'b1;
        // Reset with all inputs high, then 6-cycle latency to every filtered level
        tick(10);
        chk("rst_all_a", 64'(all_a), 64'd0);
        chk("rst_all_b", 64'(all_b), 64'd0);
        rst_n = 1'b1;
        tick(5);
        chk("lat5_start_f", 64'(a_st_f), 64'd0);
        tick(1);
        chk("lat6_flags", 64'(flags_a), 64'b1111111_00);
        tick(1);
        chk("lat7_rises", 64'({a_st_r, a_fg_r, a_ph_r}), 64'd0);

        // fg_opto: 3-cycle pulse rejected, 4-cycle pulse accepted
        fg_raw = 1'b0; tick(12);
        fg_rise_seen = 0;
        fg_raw = 1'b1; tick(3); fg_raw = 1'b0; tick(12);
        chk("fg_short_f", 64'(a_fg_f), 64'd0);
        chk("fg_short_norise", 64'(fg_rise_seen), 64'd0);
        fg_raw = 1'b1; tick(4); fg_raw = 1'b0; tick(12);
        chk("fg_len4_rise", 64'(fg_rise_seen), 64'd1);

        // Fresh reset with phase low, then 240-cycle square wave
        ph_raw = 1'b0; rst_n = 1'b0; tick(10);
        rst_n = 1'b1; tick(20);
        repeat (5) wave(120, 120);
        chk("s2_period5", 64'(a_per), 64'd240);
        chk("s2_valid5", 64'(a_valid), 64'd1);
        chk("s2_unlock5", 64'({a_lock, b_lock}), 64'd0);
        wave(120, 120);
        chk("s2_lock6", 64'({a_lock, b_lock}), 64'b11);

        // One 250-cycle period drops lock the cycle after its rise
        wave(130, 120);
        ph_raw = 1'b1; tick(6);
        chk("s3_still_locked", 64'(a_lock), 64'd1);
        tick(1);
        chk("s3_unlock", 64'(a_lock), 64'd0);
        chk("s3_period", 64'(a_per), 64'd250);
        tick(113); ph_raw = 1'b0; tick(120);
        repeat (4) wave(120, 120);
        chk("s3_not_yet", 64'(a_lock), 64'd0);
        wave(120, 120);
        chk("s3_relock", 64'({a_lock, b_lock}), 64'b11);

        // Phase glitch inside the low half
        ph_raw = 1'b1; tick(120);
        ph_raw = 1'b0; tick(40);
        ph_raw = 1'b1; tick(3); ph_raw = 1'b0; tick(10);
        chk("s4_phase_f", 64'(a_ph_f), 64'd0);
        chk("s4_glitch", 64'(a_gl), 64'(GL_ON ? 1 : 0));
        tick(67);

        // Phase stopped high: 8-bit instance saturates back to IDLE
        ph_raw = 1'b1; tick(300);
        chk("s5_b_idle", 64'({b_valid, b_lock}), 64'd0);
        chk("s5_b_period_kept", 64'(b_per), 64'd240);
        chk("s5_a_locked", 64'(a_lock), 64'd1);
        ph_raw = 1'b0; tick(120);
        repeat (5) wave(120, 120);
        chk("s5_b_not_yet", 64'(b_lock), 64'd0);
        wave(120, 120);
        chk("s5_b_relock", 64'({b_lock, b_valid}), 64'b11);

        // Async reset mid-lock, then same as the fresh-reset run
        ph_raw = 1'b1; tick(50);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_async_a", 64'(all_a), 64'd0);
        chk("s6_async_b", 64'(all_b), 64'd0);
        @(negedge clk);
        ph_raw = 1'b0; tick(10);
        rst_n = 1'b1; tick(20);
        repeat (5) wave(120, 120);
        chk("s6_unlock5", 64'({a_lock, b_lock}), 64'd0);
        chk("s6_period5", 64'(a_per), 64'd240);
        wave(120, 120);
        chk("s6_lock6", 64'({a_lock, b_lock}), 64'b11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
